// File: rtl/uart_pkt_pkg.sv
// Shared constants and state encoding for the UART command packet decoder.
// Packets are SYNC, CMD, ADDR, DATA, CKS with an 8-bit zero-sum checksum.
package uart_pkt_pkg;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
   localparam logic [7:0] DEF_CMD_WR    = 8'h57;
   localparam logic [7:0] DEF_CMD_RD    = 8'h52;
   localparam int         PKT_LEN       = 5;

   typedef enum logic [2:0] {
      IDLE,
      GET_CMD,
      GET_ADDR,
      GET_DATA,
      GET_CKS
   } pktStateT;

endpackage

// File: rtl/uart_pkt_decoder.sv
// Frames 5-byte command packets from the UART byte stream, verifies the checksum
// and issues one-cycle register read/write strobes; bad packets are flagged.
module uart_pkt_decoder
   import uart_pkt_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
   parameter logic [7:0] CMD_WR    = DEF_CMD_WR,
   parameter logic [7:0] CMD_RD    = DEF_CMD_RD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       rx_eop,
   output logic       wr_en,
   output logic       rd_en,
   output logic [7:0] addr,
   output logic [7:0] wdata,
   output logic       err_cksum,
   output logic       err_cmd,
   output logic       err_abort,
   output logic       busy
);

   // Handshake: rx_valid qualifies rx_data for exactly one cycle and is always
   // consumed that cycle (no ready); rx_eop in the same cycle discards the byte.

   pktStateT   state, stateNext;
   logic [7:0] sum, sumNext;
   logic [7:0] addrLat, addrLatNext;
   logic [7:0] dataLat, dataLatNext;
   logic       cmdIsWr, cmdIsWrNext;
   logic [7:0] addrNext, wdataNext;
   logic       wrNext, rdNext, cksErrNext, cmdErrNext, abortNext;
   logic [7:0] cksTotal;

   assign cksTotal = sum + rx_data;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sum       <= 8'h00;
         addrLat   <= 8'h00;
         dataLat   <= 8'h00;
         cmdIsWr   <= 1'b0;
         addr      <= 8'h00;
         wdata     <= 8'h00;
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         err_cksum <= 1'b0;
         err_cmd   <= 1'b0;
         err_abort <= 1'b0;
      end else begin
         state     <= stateNext;
         sum       <= sumNext;
         addrLat   <= addrLatNext;
         dataLat   <= dataLatNext;
         cmdIsWr   <= cmdIsWrNext;
         addr      <= addrNext;
         wdata     <= wdataNext;
         wr_en     <= wrNext;
         rd_en     <= rdNext;
         err_cksum <= cksErrNext;
         err_cmd   <= cmdErrNext;
         err_abort <= abortNext;
      end
   end

   always_comb begin
      stateNext   = state;
      sumNext     = sum;
      addrLatNext = addrLat;
      dataLatNext = dataLat;
      cmdIsWrNext = cmdIsWr;
      addrNext    = addr;
      wdataNext   = wdata;
      wrNext      = 1'b0;
      rdNext      = 1'b0;
      cksErrNext  = 1'b0;
      cmdErrNext  = 1'b0;
      abortNext   = 1'b0;

      // End-of-packet takes priority over any byte arriving alongside it.
      if (rx_eop) begin
         if (state != IDLE) begin
            stateNext = IDLE;
            abortNext = 1'b1;
         end
      end else if (rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_data == SYNC_BYTE) stateNext = GET_CMD;
            end
            GET_CMD: begin
               if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                  cmdIsWrNext = (rx_data == CMD_WR);
                  sumNext     = rx_data;
                  stateNext   = GET_ADDR;
               end else begin
                  cmdErrNext = 1'b1;
                  stateNext  = IDLE;
               end
            end
            GET_ADDR: begin
               addrLatNext = rx_data;
               sumNext     = sum + rx_data;
               stateNext   = GET_DATA;
            end
            GET_DATA: begin
               dataLatNext = rx_data;
               sumNext     = sum + rx_data;
               stateNext   = GET_CKS;
            end
            GET_CKS: begin
               if (cksTotal == 8'h00) begin
                  wrNext    = cmdIsWr;
                  rdNext    = !cmdIsWr;
                  addrNext  = addrLat;
                  wdataNext = dataLat;
               end else begin
                  cksErrNext = 1'b1;
               end
               stateNext = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

endmodule
